sdram_burst_responder: RTL and testbench

//  Serves the video block's SDRAM burst-read port (sd_rd / sd_rd_addr / sd_end_burst -> sd_data_available / sd_out).

---
 rtl/video_sdram_pkg.sv | 33 +++
 rtl/sdram_burst_responder.sv | 157 +++++++++++++++
 tb/tb_sdram_burst_responder.sv | 300 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/video_sdram_pkg.sv
// ---------------------------------------------------------------------------
// video_sdram_pkg
//
// Shared types and constants for the video-side SDRAM burst path.
//   SDRAM_ADDR_W  : word-address width on both the video and controller ports
//   SDRAM_DATA_W  : width of one SDRAM data word
//   burst_state_t : burst responder state encoding
//   next_word_addr: sequential address step, wrapping silently at the top
// ---------------------------------------------------------------------------
package video_sdram_pkg;

    localparam int SDRAM_ADDR_W = 25;
    localparam int SDRAM_DATA_W = 16;

    // IDLE  : no burst in progress
    // ISSUE : waiting for the controller to accept the next word read
    // WAIT  : one read outstanding, waiting for its data
    // DRAIN : burst was ended early, swallowing the outstanding word
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DRAIN = 2'd3
    } burst_state_t;

    // Address increment; the natural modulo-2^SDRAM_ADDR_W wrap is intended.
    function automatic logic [SDRAM_ADDR_W-1:0] next_word_addr(
        input logic [SDRAM_ADDR_W-1:0] addr
    );
        return addr + 1'b1;
    endfunction

endpackage

// File: rtl/sdram_burst_responder.sv
// ---------------------------------------------------------------------------
// sdram_burst_responder
//
// Serves the video block's burst-read port by turning each burst request into
// a run of single-word reads on the SDRAM controller port. One word is handed
// back to video for every controller completion until video ends the burst or
// MAX_BURST words have been returned. Only one controller read is ever
// outstanding. All outputs are registered.
//
// Parameters
//   MAX_BURST : words after which a burst ends by itself (power of 2, >= 2)
//   ADDR_W    : word-address width
//
// Ports
//   clk_sys_99_287    in   sole clock, rising edge
//   reset             in   asynchronous, active-high
//   sd_rd             in   one-cycle burst start request
//   sd_rd_addr        in   first word address, sampled with sd_rd
//   sd_end_burst      in   requester wants no more words
//   sd_data_available out  one-cycle strobe, sd_out valid
//   sd_out            out  returned word
//   sd_busy           out  burst active, draining, or a request is pending
//   burst_done        out  one-cycle pulse when a burst fully terminates
//   ctrl_rd           out  one-cycle word-read command to the controller
//   ctrl_addr         out  word address for ctrl_rd
//   ctrl_busy         in   controller cannot accept ctrl_rd this cycle
//   ctrl_data_valid   in   one-cycle strobe, ctrl_q holds the requested word
//   ctrl_q            in   controller read data
// ---------------------------------------------------------------------------
module sdram_burst_responder
    import video_sdram_pkg::*;
#(
    parameter int MAX_BURST = 256,
    parameter int ADDR_W    = SDRAM_ADDR_W
) (
    input  logic                    clk_sys_99_287,
    input  logic                    reset,
    input  logic                    sd_rd,
    input  logic [ADDR_W-1:0]       sd_rd_addr,
    input  logic                    sd_end_burst,
    output logic                    sd_data_available,
    output logic [SDRAM_DATA_W-1:0] sd_out,
    output logic                    sd_busy,
    output logic                    burst_done,
    output logic                    ctrl_rd,
    output logic [ADDR_W-1:0]       ctrl_addr,
    input  logic                    ctrl_busy,
    input  logic                    ctrl_data_valid,
    input  logic [SDRAM_DATA_W-1:0] ctrl_q
);

    localparam int CNT_W = $clog2(MAX_BURST) + 1;

    // Count value held while the final word of a maximum-length burst is
    // outstanding; its completion ends the burst.
    localparam logic [CNT_W-1:0] LAST_COUNT = CNT_W'(MAX_BURST - 1);

    burst_state_t      state;
    logic [ADDR_W-1:0] addr;
    logic [CNT_W-1:0]  count;
    logic              pending;
    logic [ADDR_W-1:0] pending_addr;

    // Burst state machine with all outputs registered.
    // sd_busy is only rewritten when the machine leaves or enters IDLE: while
    // a burst is active it is already 1, and on the way back to IDLE it stays
    // up if a request is (or is just becoming) pending.
    always_ff @(posedge clk_sys_99_287 or posedge reset) begin
        if (reset) begin
            state             <= IDLE;
            addr              <= '0;
            count             <= '0;
            pending           <= 1'b0;
            pending_addr      <= '0;
            sd_data_available <= 1'b0;
            sd_out            <= '0;
            sd_busy           <= 1'b0;
            burst_done        <= 1'b0;
            ctrl_rd           <= 1'b0;
            ctrl_addr         <= '0;
        end else begin
            ctrl_rd           <= 1'b0;
            sd_data_available <= 1'b0;
            burst_done        <= 1'b0;

            // A request arriving mid-burst is parked; a newer one replaces it.
            if (state != IDLE && sd_rd) begin
                pending      <= 1'b1;
                pending_addr <= sd_rd_addr;
            end

            case (state)
                IDLE: begin
                    // A live request is newer than a parked one, so it wins.
                    if (sd_rd || pending) begin
                        addr    <= sd_rd ? sd_rd_addr : pending_addr;
                        count   <= '0;
                        pending <= 1'b0;
                        sd_busy <= 1'b1;
                        state   <= ISSUE;
                    end else begin
                        sd_busy <= 1'b0;
                    end
                end

                ISSUE: begin
                    // Nothing is outstanding here, so an end request can
                    // finish the burst immediately.
                    if (sd_end_burst) begin
                        burst_done <= 1'b1;
                        sd_busy    <= pending | sd_rd;
                        state      <= IDLE;
                    end else if (!ctrl_busy) begin
                        ctrl_rd   <= 1'b1;
                        ctrl_addr <= addr;
                        state     <= WAIT;
                    end
                end

                WAIT: begin
                    // A word arriving together with an end request is still
                    // delivered; the end request then closes the burst.
                    if (ctrl_data_valid) begin
                        sd_out            <= ctrl_q;
                        sd_data_available <= 1'b1;
                        addr              <= next_word_addr(addr);
                        count             <= count + 1'b1;
                        if (sd_end_burst || count == LAST_COUNT) begin
                            burst_done <= 1'b1;
                            sd_busy    <= pending | sd_rd;
                            state      <= IDLE;
                        end else begin
                            state <= ISSUE;
                        end
                    end else if (sd_end_burst) begin
                        state <= DRAIN;
                    end
                end

                DRAIN: begin
                    // The outstanding word must still be absorbed before the
                    // controller port is free; it is dropped, not delivered.
                    if (ctrl_data_valid) begin
                        burst_done <= 1'b1;
                        sd_busy    <= pending | sd_rd;
                        state      <= IDLE;
                    end
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sdram_burst_responder.sv
// ---------------------------------------------------------------------------
// tb_sdram_burst_responder
//
// Directed bench for sdram_burst_responder (built with MAX_BURST = 4).
// The stimulus process plays both the video requester and the SDRAM
// controller; for every read, word and burst end it expects, it pushes the
// hand-computed value into a queue. A negedge monitor pops and compares each
// time the DUT presents ctrl_rd, sd_data_available or burst_done.
// ---------------------------------------------------------------------------
module tb_sdram_burst_responder;
    import video_sdram_pkg::*;

    localparam int MAX_BURST = 4;
    localparam int BUDGET    = 50;

    logic                    clk_sys_99_287 = 1'b0;
    logic                    reset;
    logic                    sd_rd;
    logic [SDRAM_ADDR_W-1:0] sd_rd_addr;
    logic                    sd_end_burst;
    logic                    sd_data_available;
    logic [SDRAM_DATA_W-1:0] sd_out;
    logic                    sd_busy;
    logic                    burst_done;
    logic                    ctrl_rd;
    logic [SDRAM_ADDR_W-1:0] ctrl_addr;
    logic                    ctrl_busy;
    logic                    ctrl_data_valid;
    logic [SDRAM_DATA_W-1:0] ctrl_q;

    int n_checks = 0;
    int n_pass   = 0;

    logic [SDRAM_ADDR_W-1:0] exp_addr_q[$];
    logic [SDRAM_DATA_W-1:0] exp_data_q[$];
    bit                      exp_done_q[$];

    sdram_burst_responder #(
        .MAX_BURST(MAX_BURST),
        .ADDR_W   (SDRAM_ADDR_W)
    ) dut (
        .clk_sys_99_287   (clk_sys_99_287),
        .reset            (reset),
        .sd_rd            (sd_rd),
        .sd_rd_addr       (sd_rd_addr),
        .sd_end_burst     (sd_end_burst),
        .sd_data_available(sd_data_available),
        .sd_out           (sd_out),
        .sd_busy          (sd_busy),
        .burst_done       (burst_done),
        .ctrl_rd          (ctrl_rd),
        .ctrl_addr        (ctrl_addr),
        .ctrl_busy        (ctrl_busy),
        .ctrl_data_valid  (ctrl_data_valid),
        .ctrl_q           (ctrl_q)
    );

    always #5 clk_sys_99_287 = ~clk_sys_99_287;

    // Hard stop in case something wedges outside the bounded waits.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic report_unexpected(input string name, input logic [31:0] act);
        n_checks++;
        $display("[TB] FAIL %s: got unexpected event (value 0x%0h), expected none", name, act);
    endtask

    // Scoreboard monitor: every DUT output event must match the next queued
    // expectation, and events with nothing queued are failures.
    always @(negedge clk_sys_99_287) begin
        if (ctrl_rd) begin
            if (exp_addr_q.size() == 0) report_unexpected("ctrl_rd", 32'(ctrl_addr));
            else check_output("ctrl_addr", 32'(ctrl_addr), 32'(exp_addr_q.pop_front()));
        end
        if (sd_data_available) begin
            if (exp_data_q.size() == 0) report_unexpected("sd_data_available", 32'(sd_out));
            else check_output("sd_out", 32'(sd_out), 32'(exp_data_q.pop_front()));
        end
        if (burst_done) begin
            n_checks++;
            if (exp_done_q.size() == 0)
                $display("[TB] FAIL burst_done: got unexpected pulse, expected none");
            else begin
                void'(exp_done_q.pop_front());
                n_pass++;
            end
        end
    end

    task automatic tick();
        @(posedge clk_sys_99_287);
        #1;
    endtask

    // Pulse sd_rd for one cycle; returns one cycle after the request cycle.
    task automatic apply_stimulus(input logic [SDRAM_ADDR_W-1:0] a);
        sd_rd      = 1'b1;
        sd_rd_addr = a;
        tick();
        sd_rd      = 1'b0;
    endtask

    // Wait (bounded) until ctrl_rd is visible; reports cycles waited.
    task automatic wait_ctrl_rd(input string name, output int waited);
        waited = 0;
        while (!ctrl_rd && waited < BUDGET) begin
            tick();
            waited++;
        end
        if (!ctrl_rd) begin
            n_checks++;
            $display("[TB] FAIL %s: got no ctrl_rd within %0d cycles, expected one", name, BUDGET);
        end
    endtask

    // Controller model: called in the cycle ctrl_rd is seen, returns q after
    // lat cycles, optionally with sd_end_burst alongside. Returns in the cycle
    // after ctrl_data_valid, where the returned word should be strobed.
    task automatic serve(input logic [SDRAM_DATA_W-1:0] q, input int lat,
                         input logic end_with, input logic exp_strobe);
        repeat (lat) tick();
        ctrl_data_valid = 1'b1;
        ctrl_q          = q;
        sd_end_burst    = end_with;
        tick();
        ctrl_data_valid = 1'b0;
        sd_end_burst    = 1'b0;
        check_output("strobe_latency", 32'(sd_data_available), 32'(exp_strobe));
    endtask

    // Let the monitor catch up, then insist every expectation was consumed.
    task automatic end_test(input string name);
        repeat (3) tick();
        check_output({name, "_addr_left"}, exp_addr_q.size(), 0);
        check_output({name, "_data_left"}, exp_data_q.size(), 0);
        check_output({name, "_done_left"}, exp_done_q.size(), 0);
        check_output({name, "_idle"}, 32'(sd_busy), 0);
    endtask

    initial begin
        int w;
        reset           = 1'b1;
        sd_rd           = 1'b0;
        sd_rd_addr      = '0;
        sd_end_burst    = 1'b0;
        ctrl_busy       = 1'b0;
        ctrl_data_valid = 1'b0;
        ctrl_q          = '0;

        // Reset state.
        repeat (2) tick();
        check_output("rst_sd_data_available", 32'(sd_data_available), 0);
        check_output("rst_sd_out", 32'(sd_out), 0);
        check_output("rst_sd_busy", 32'(sd_busy), 0);
        check_output("rst_burst_done", 32'(burst_done), 0);
        check_output("rst_ctrl_rd", 32'(ctrl_rd), 0);
        check_output("rst_ctrl_addr", 32'(ctrl_addr), 0);
        reset = 1'b0;
        tick();

        // T1: 4-word burst at 0x100, latency 3; end request afterwards is ignored.
        $display("[TB] T1 burst at 0x100");
        exp_addr_q = '{25'h100, 25'h101, 25'h102, 25'h103};
        exp_data_q = '{16'hA001, 16'hA002, 16'hA003, 16'hA004};
        exp_done_q = '{1'b1};
        apply_stimulus(25'h100);
        wait_ctrl_rd("t1_rd0", w);
        check_output("t1_first_rd_latency", w, 1);
        serve(16'hA001, 3, 1'b0, 1'b1);
        wait_ctrl_rd("t1_rd1", w);
        serve(16'hA002, 3, 1'b0, 1'b1);
        wait_ctrl_rd("t1_rd2", w);
        serve(16'hA003, 3, 1'b0, 1'b1);
        wait_ctrl_rd("t1_rd3", w);
        serve(16'hA004, 3, 1'b0, 1'b1);
        check_output("t1_done_timing", 32'(burst_done), 1);
        sd_end_burst = 1'b1;
        tick();
        sd_end_burst = 1'b0;
        check_output("t1_no_rd_after", 32'(ctrl_rd), 0);
        end_test("t1");

        // T1b: end request coincident with the 2nd word: word delivered, burst ends.
        $display("[TB] T1b end with data at 0x40");
        exp_addr_q = '{25'h40, 25'h41};
        exp_data_q = '{16'h0B01, 16'h0B02};
        exp_done_q = '{1'b1};
        apply_stimulus(25'h40);
        wait_ctrl_rd("t1b_rd0", w);
        serve(16'h0B01, 2, 1'b0, 1'b1);
        wait_ctrl_rd("t1b_rd1", w);
        serve(16'h0B02, 2, 1'b1, 1'b1);
        check_output("t1b_done_timing", 32'(burst_done), 1);
        end_test("t1b");

        // T2: address wrap across the top of the space, MAX_BURST self-termination.
        $display("[TB] T2 wrap at 0x1FFFFFE");
        exp_addr_q = '{25'h1FFFFFE, 25'h1FFFFFF, 25'h0, 25'h1};
        exp_data_q = '{16'h2001, 16'h2002, 16'h2003, 16'h2004};
        exp_done_q = '{1'b1};
        apply_stimulus(25'h1FFFFFE);
        for (int i = 0; i < 4; i++) begin
            wait_ctrl_rd("t2_rd", w);
            serve(16'h2001 + 16'(i), 1, 1'b0, 1'b1);
        end
        check_output("t2_done_timing", 32'(burst_done), 1);
        end_test("t2");

        // T3: end request in WAIT before data; the word is dropped.
        $display("[TB] T3 drain");
        exp_addr_q = '{25'h500};
        exp_done_q = '{1'b1};
        apply_stimulus(25'h500);
        wait_ctrl_rd("t3_rd0", w);
        tick();
        sd_end_burst = 1'b1;
        tick();
        sd_end_burst = 1'b0;
        tick();
        serve(16'hDEAD, 0, 1'b0, 1'b0);
        check_output("t3_done_timing", 32'(burst_done), 1);
        end_test("t3");

        // T4: ctrl_busy held for 5 ISSUE cycles; exactly one ctrl_rd after release.
        $display("[TB] T4 ctrl_busy stall");
        exp_addr_q = '{25'h600};
        exp_data_q = '{16'h6006};
        exp_done_q = '{1'b1};
        ctrl_busy = 1'b1;
        apply_stimulus(25'h600);
        for (int i = 0; i < 5; i++) begin
            tick();
            check_output("t4_rd_stalled", 32'(ctrl_rd), 0);
        end
        ctrl_busy = 1'b0;
        tick();
        check_output("t4_rd_pulse", 32'(ctrl_rd), 1);
        tick();
        check_output("t4_rd_single", 32'(ctrl_rd), 0);
        serve(16'h6006, 0, 1'b1, 1'b1);
        end_test("t4");

        // T5: two requests mid-burst; only the newer one (0x300) is served.
        $display("[TB] T5 pending overwrite");
        exp_addr_q = '{25'h700, 25'h300};
        exp_data_q = '{16'h7777, 16'h3333};
        exp_done_q = '{1'b1, 1'b1};
        apply_stimulus(25'h700);
        wait_ctrl_rd("t5_rd0", w);
        apply_stimulus(25'h200);
        tick();
        apply_stimulus(25'h300);
        check_output("t5_busy_pending", 32'(sd_busy), 1);
        serve(16'h7777, 1, 1'b1, 1'b1);
        check_output("t5_busy_after_done", 32'(sd_busy), 1);
        wait_ctrl_rd("t5_rd1", w);
        check_output("t5_pending_latency", w, 2);
        serve(16'h3333, 1, 1'b1, 1'b1);
        end_test("t5");

        // T6: reset in WAIT; late data ignored; fresh burst works.
        $display("[TB] T6 reset mid-burst");
        exp_addr_q = '{25'h800};
        apply_stimulus(25'h800);
        wait_ctrl_rd("t6_rd0", w);
        tick();
        reset = 1'b1;
        #1;
        check_output("t6_rst_busy", 32'(sd_busy), 0);
        check_output("t6_rst_ctrl_addr", 32'(ctrl_addr), 0);
        tick();
        reset = 1'b0;
        tick();
        serve(16'hBAD0, 0, 1'b0, 1'b0);
        tick();
        check_output("t6_idle_after_late", 32'(sd_busy), 0);
        exp_addr_q.push_back(25'h900);
        exp_data_q.push_back(16'h9009);
        exp_done_q.push_back(1'b1);
        apply_stimulus(25'h900);
        wait_ctrl_rd("t6_rd1", w);
        check_output("t6_fresh_latency", w, 1);
        serve(16'h9009, 2, 1'b1, 1'b1);
        end_test("t6");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
